brick_mem_arbiter: RTL and testbench
====================================

Name: brick_mem_arbiter

Overview:
Owns the single-port brick health RAM and shares it between three requesters.
- Level loader: writes each brick's initial health.
- Ball-collision unit: read-modify-write decrement of a hit brick.
- Brick renderer: reads a brick's health for drawing.

It also tracks the level's remaining total hit points and flags level clear. It sits between the level loader, the collision logic and the VGA draw path, and is the only block that drives the brick RAM.

Parameters:
ADDR_W, 10, brick address width
HP_W, 2, per-brick health width
TOT_W, 10, total-health counter width
BRICKNUM, 352, number of valid brick addresses (0..BRICKNUM-1)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
ld_init  in  1  one-cycle pulse: load hp_remaining from ld_total
ld_total  in  TOT_W  level total health, sampled on ld_init
ld_req  in  1  loader write request
ld_addr  in  ADDR_W  loader brick address
ld_health  in  HP_W  loader health value
ld_ack  out  1  one-cycle pulse: write performed
hit_req  in  1  collision decrement request
hit_addr  in  ADDR_W  brick that was hit
hit_ack  out  1  one-cycle pulse: hit resolved
hit_alive  out  1  valid with hit_ack: brick had health>0 before the hit
rd_req  in  1  renderer read request
rd_addr  in  ADDR_W  brick to read
rd_ack  out  1  one-cycle pulse: rd_health valid
rd_health  out  HP_W  read data, held until the next rd_ack
mem_addr  out  ADDR_W  RAM address
mem_wdata  out  HP_W  RAM write data
mem_we  out  1  RAM write enable
mem_rdata  in  HP_W  RAM read data, 1-cycle synchronous latency
hp_remaining  out  TOT_W  remaining level hit points
level_clear  out  1  high when loaded and hp_remaining==0

Behaviour:
- Reset (async, active-high):
  - State goes to S_IDLE.
  - All acks, hit_alive, mem_we, mem_addr, mem_wdata, rd_health, hp_remaining and level_clear go to 0.
  - The internal loaded flag clears.
  - Reset mid-transaction abandons it: no write, no ack.
- Handshake:
  - A requester holds req and operands stable until its ack.
  - ack is a single-cycle pulse.
  - Operands are latched on grant in S_IDLE.
- Arbitration in S_IDLE uses fixed priority: ld > hit > rd. The FSM returns to S_IDLE after every transaction, so there is at least one idle cycle between grants.
- FSM (one-hot or binary, implementer's choice):
  - S_IDLE: grant the highest-priority request; otherwise stay.
  - S_LDWR:
    - mem_addr=ld_addr, mem_wdata=ld_health, mem_we=1, ld_ack=1.
    - Next state S_IDLE. Latency from grant to ack: 1 cycle.
  - S_HITRD:
    - mem_addr=hit_addr.
    - If hit_addr>=BRICKNUM: hit_ack=1, hit_alive=0, no RAM access, next S_IDLE.
    - Otherwise next S_HITCHK.
  - S_HITCHK: mem_rdata is valid.
    - If 0: hit_ack=1, hit_alive=0, next S_IDLE.
    - Else next S_HITWR.
  - S_HITWR:
    - mem_we=1, mem_wdata=rdata-1 (latched), hit_ack=1, hit_alive=1.
    - hp_remaining decrements by 1, saturating at 0.
    - Next S_IDLE.
  - S_RDRD:
    - mem_addr=rd_addr.
    - If rd_addr>=BRICKNUM: rd_health=0, rd_ack=1, next S_IDLE.
    - Otherwise next S_RDDONE.
  - S_RDDONE: rd_health<=mem_rdata, rd_ack=1, next S_IDLE.
- hp_remaining and level_clear:
  - ld_init sets hp_remaining<=ld_total, sets loaded=1 and clears level_clear.
  - ld_init coinciding with an S_HITWR decrement: ld_init wins.
  - level_clear is registered: level_clear = loaded && hp_remaining==0, visible the cycle after the decrement that reaches 0.
  - ld_init with ld_total=0 gives level_clear=1 the next cycle.
- The renderer may starve during loading. This is accepted, because loading precedes play.

Decomposition:
- Shared macros file: BRICKNUM (existing), plus new ARB_* state encodings and HP_W/TOT_W width constants.
- One natural sub-module: brick_hp_tracker, holding hp_remaining, the loaded flag, the saturating decrement and level_clear. Inputs: clk, reset, ld_init, ld_total, dec. Outputs: hp_remaining, level_clear.

Test Plan:
- Reset during S_HITWR preamble: assert reset while in S_HITCHK on addr 5 holding health 2 -> mem_we never asserts, RAM[5] stays 2, all outputs 0.
- Loader fill: ld_init with ld_total=3, then ld_req writes addr 17=1 and addr 18=2 -> each ld_ack one cycle after grant, RAM matches, hp_remaining=3, level_clear=0.
- Collision decrement: hit_req addr 18 (health 2) -> hit_ack 3 cycles after grant with hit_alive=1, RAM[18]=1, hp_remaining=2. A second hit on addr 20 (health 0) -> hit_alive=0, no write, hp_remaining unchanged.
- Priority: ld_req, hit_req and rd_req all rise in the same cycle -> ld_ack first, then hit_ack, then rd_ack, each separated by at least one idle cycle.
- Out-of-range: rd_addr=352 -> rd_ack with rd_health=0 and no RAM read. hit_addr=400 -> hit_alive=0.
- Level clear: ld_total=1 with one brick of health 1, then hit it -> hp_remaining=0 and level_clear=1 the next cycle. A further ld_init clears it.

Source files
------------

// File: rtl/brick_mem_arbiter_pkg.sv
// Shared constants and types for the brick health RAM arbiter.
//   ARB_BRICKNUM : number of valid brick addresses (0..ARB_BRICKNUM-1)
//   ARB_ADDR_W   : brick address width
//   ARB_HP_W     : per-brick health width
//   ARB_TOT_W    : level total-health counter width
//   arb_state_t  : arbiter FSM encoding
package brick_mem_arbiter_pkg;

  localparam int unsigned ARB_BRICKNUM = 352;
  localparam int          ARB_ADDR_W   = 10;
  localparam int          ARB_HP_W     = 2;
  localparam int          ARB_TOT_W    = 10;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LDWR   = 3'd1,
    S_HITRD  = 3'd2,
    S_HITCHK = 3'd3,
    S_HITWR  = 3'd4,
    S_RDRD   = 3'd5,
    S_RDDONE = 3'd6
  } arb_state_t;

  function automatic logic in_range(input int unsigned addr, input int unsigned num);
    return addr < num;
  endfunction

endpackage

// File: rtl/brick_mem_arbiter_hp_tracker.sv
// brick_hp_tracker: remaining level hit points and level-clear flag.
//   clk, reset   : clock, async active-high reset
//   ld_init      : load hp_remaining from ld_total, mark level loaded
//   ld_total     : level total health
//   dec          : decrement hp_remaining by one, saturating at 0
//   hp_remaining : remaining hit points
//   level_clear  : registered, loaded && hp_remaining == 0
module brick_hp_tracker
  import brick_mem_arbiter_pkg::*;
#(
  parameter int TOT_W = ARB_TOT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ld_init,
  input  logic [TOT_W-1:0] ld_total,
  input  logic             dec,
  output logic [TOT_W-1:0] hp_remaining,
  output logic             level_clear
);

  logic             loaded;
  logic             loaded_nxt;
  logic [TOT_W-1:0] hp_nxt;

  // ld_init takes precedence over a coincident decrement.
  always_comb begin
    hp_nxt     = hp_remaining;
    loaded_nxt = loaded;
    if (ld_init) begin
      hp_nxt     = ld_total;
      loaded_nxt = 1'b1;
    end else if (dec && hp_remaining != '0) begin
      hp_nxt = hp_remaining - TOT_W'(1);
    end
  end

  // level_clear is computed from the next values so it lands on the same
  // edge as the decrement (or load) that makes the total zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hp_remaining <= '0;
      loaded       <= 1'b0;
      level_clear  <= 1'b0;
    end else begin
      hp_remaining <= hp_nxt;
      loaded       <= loaded_nxt;
      level_clear  <= loaded_nxt && (hp_nxt == '0);
    end
  end

endmodule

// File: rtl/brick_mem_arbiter.sv
// brick_mem_arbiter: sole owner of the single-port brick health RAM.
// Shares it between the level loader (write), the collision unit
// (read-modify-write decrement) and the renderer (read), fixed priority
// ld > hit > rd, one transaction at a time with an idle cycle between grants.
//   ld_*     : loader write port, ld_init/ld_total load the level total
//   hit_*    : collision decrement port, hit_alive valid with hit_ack
//   rd_*     : renderer read port, rd_health held until the next rd_ack
//   mem_*    : RAM port, mem_rdata has one cycle of read latency
//   hp_remaining, level_clear : level progress
module brick_mem_arbiter
  import brick_mem_arbiter_pkg::*;
#(
  parameter int          ADDR_W   = ARB_ADDR_W,
  parameter int          HP_W     = ARB_HP_W,
  parameter int          TOT_W    = ARB_TOT_W,
  parameter int unsigned BRICKNUM = ARB_BRICKNUM
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_init,
  input  logic [TOT_W-1:0]  ld_total,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [HP_W-1:0]   ld_health,
  output logic              ld_ack,
  input  logic              hit_req,
  input  logic [ADDR_W-1:0] hit_addr,
  output logic              hit_ack,
  output logic              hit_alive,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ack,
  output logic [HP_W-1:0]   rd_health,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [HP_W-1:0]   mem_wdata,
  output logic              mem_we,
  input  logic [HP_W-1:0]   mem_rdata,
  output logic [TOT_W-1:0]  hp_remaining,
  output logic              level_clear
);

  arb_state_t        state, state_nxt;
  logic [ADDR_W-1:0] addr_q;      // operand address latched on grant
  logic [HP_W-1:0]   data_q;      // write data: ld_health or rdata-1
  logic [HP_W-1:0]   rd_health_q;
  logic              addr_ok;
  logic              dec;

  assign addr_ok = in_range(32'(addr_q), BRICKNUM);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    ld_ack    = 1'b0;
    hit_ack   = 1'b0;
    hit_alive = 1'b0;
    rd_ack    = 1'b0;
    rd_health = rd_health_q;
    dec       = 1'b0;
    case (state)
      S_IDLE: begin
        if      (ld_req)  state_nxt = S_LDWR;
        else if (hit_req) state_nxt = S_HITRD;
        else if (rd_req)  state_nxt = S_RDRD;
      end
      S_LDWR: begin
        mem_addr  = addr_q;
        mem_wdata = data_q;
        mem_we    = 1'b1;
        ld_ack    = 1'b1;
        state_nxt = S_IDLE;
      end
      S_HITRD: begin
        mem_addr = addr_q;
        if (!addr_ok) begin
          hit_ack   = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          state_nxt = S_HITCHK;
        end
      end
      S_HITCHK: begin
        mem_addr = addr_q;
        if (mem_rdata == '0) begin
          hit_ack   = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          state_nxt = S_HITWR;
        end
      end
      S_HITWR: begin
        mem_addr  = addr_q;
        mem_wdata = data_q;
        mem_we    = 1'b1;
        hit_ack   = 1'b1;
        hit_alive = 1'b1;
        dec       = 1'b1;
        state_nxt = S_IDLE;
      end
      S_RDRD: begin
        mem_addr = addr_q;
        if (!addr_ok) begin
          rd_health = '0;
          rd_ack    = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          state_nxt = S_RDDONE;
        end
      end
      S_RDDONE: begin
        // Forward the RAM data during the ack cycle; the register holds it after.
        rd_health = mem_rdata;
        rd_ack    = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q      <= '0;
      data_q      <= '0;
      rd_health_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ld_req) begin
            addr_q <= ld_addr;
            data_q <= ld_health;
          end else if (hit_req) begin
            addr_q <= hit_addr;
          end else if (rd_req) begin
            addr_q <= rd_addr;
          end
        end
        S_HITCHK: data_q <= mem_rdata - HP_W'(1);
        S_RDRD:   if (!addr_ok) rd_health_q <= '0;
        S_RDDONE: rd_health_q <= mem_rdata;
        default: ;
      endcase
    end
  end

  brick_hp_tracker #(.TOT_W(TOT_W)) u_hp (
    .clk          (clk),
    .reset        (reset),
    .ld_init      (ld_init),
    .ld_total     (ld_total),
    .dec          (dec),
    .hp_remaining (hp_remaining),
    .level_clear  (level_clear)
  );

endmodule

// File: tb/tb_brick_mem_arbiter.sv
module tb_brick_mem_arbiter;

  localparam int AW   = 10;
  localparam int HW   = 2;
  localparam int TW   = 10;
  localparam int BNUM = 352;

  logic          clk = 1'b0;
  logic          reset;
  logic          ld_init;
  logic [TW-1:0] ld_total;
  logic          ld_req;
  logic [AW-1:0] ld_addr;
  logic [HW-1:0] ld_health;
  logic          ld_ack;
  logic          hit_req;
  logic [AW-1:0] hit_addr;
  logic          hit_ack;
  logic          hit_alive;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          rd_ack;
  logic [HW-1:0] rd_health;
  logic [AW-1:0] mem_addr;
  logic [HW-1:0] mem_wdata;
  logic          mem_we;
  logic [HW-1:0] mem_rdata;
  logic [TW-1:0] hp_remaining;
  logic          level_clear;

  always #5 clk = ~clk;

  brick_mem_arbiter dut (
    .clk(clk), .reset(reset),
    .ld_init(ld_init), .ld_total(ld_total),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_health(ld_health), .ld_ack(ld_ack),
    .hit_req(hit_req), .hit_addr(hit_addr), .hit_ack(hit_ack), .hit_alive(hit_alive),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_health(rd_health),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .hp_remaining(hp_remaining), .level_clear(level_clear)
  );

  // Environment RAM: synchronous read, one cycle latency.
  logic [HW-1:0] mem [0:1023];
  logic          mem_clr;
  int            wr_cnt = 0;
  always @(posedge clk) begin
    mem_rdata <= mem[mem_addr];
    if (mem_clr) begin
      for (int i = 0; i < 1024; i++) mem[i] <= '0;
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
      wr_cnt <= wr_cnt + 1;
    end
  end

  // Reference model: brick health table plus level totals.
  logic [HW-1:0] ref_ram [0:1023];
  int            ref_hp;
  bit            ref_loaded;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_level(input string tag);
    check({tag, "_hp"}, 32'(hp_remaining), 32'(ref_hp));
    check({tag, "_clear"}, 32'(level_clear), 32'(ref_loaded && ref_hp == 0));
  endtask

  task automatic do_init(input int total);
    @(negedge clk);
    ld_init = 1'b1; ld_total = TW'(total);
    @(negedge clk);
    ld_init = 1'b0;
    ref_hp = total; ref_loaded = 1'b1;
    check_level("init");
  endtask

  task automatic do_ld(input int a, input int h);
    int cyc, w0;
    w0 = wr_cnt;
    @(negedge clk);
    ld_req = 1'b1; ld_addr = AW'(a); ld_health = HW'(h); cyc = 0;
    do begin @(negedge clk); cyc++; end while (!ld_ack && cyc < 20);
    ld_req = 1'b0;
    check("ld_lat", 32'(cyc), 32'd1);
    ref_ram[a] = HW'(h);
    @(negedge clk);
    check("ld_pulse", 32'(ld_ack), 32'd0);
    check("ld_wr", 32'(wr_cnt - w0), 32'd1);
    check("ld_mem", 32'(mem[a]), 32'(ref_ram[a]));
  endtask

  task automatic do_hit(input int a);
    int cyc, w0, lat_e;
    bit alive_e;
    alive_e = (a < BNUM) && (ref_ram[a] != 0);
    lat_e   = (a >= BNUM) ? 1 : (alive_e ? 3 : 2);
    w0 = wr_cnt;
    @(negedge clk);
    hit_req = 1'b1; hit_addr = AW'(a); cyc = 0;
    do begin @(negedge clk); cyc++; end while (!hit_ack && cyc < 20);
    hit_req = 1'b0;
    check("hit_lat", 32'(cyc), 32'(lat_e));
    check("hit_alive", 32'(hit_alive), 32'(alive_e));
    if (alive_e) begin
      ref_ram[a] = ref_ram[a] - 2'd1;
      if (ref_hp != 0) ref_hp--;
    end
    @(negedge clk);
    check("hit_pulse", 32'(hit_ack), 32'd0);
    check("hit_wr", 32'(wr_cnt - w0), 32'(alive_e));
    check("hit_mem", 32'(mem[a]), 32'(ref_ram[a]));
    check_level("hit");
  endtask

  task automatic do_rd(input int a);
    int cyc, lat_e;
    logic [HW-1:0] exp_d;
    exp_d = (a < BNUM) ? ref_ram[a] : '0;
    lat_e = (a < BNUM) ? 2 : 1;
    @(negedge clk);
    rd_req = 1'b1; rd_addr = AW'(a); cyc = 0;
    do begin @(negedge clk); cyc++; end while (!rd_ack && cyc < 20);
    rd_req = 1'b0;
    check("rd_lat", 32'(cyc), 32'(lat_e));
    check("rd_data", 32'(rd_health), 32'(exp_d));
    @(negedge clk);
    check("rd_pulse", 32'(rd_ack), 32'd0);
    check("rd_hold", 32'(rd_health), 32'(exp_d));
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_acks"}, {29'd0, ld_ack, hit_ack, rd_ack}, 32'd0);
    check({tag, "_alive"}, 32'(hit_alive), 32'd0);
    check({tag, "_we"}, 32'(mem_we), 32'd0);
    check({tag, "_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_wdata"}, 32'(mem_wdata), 32'd0);
    check({tag, "_rdh"}, 32'(rd_health), 32'd0);
    check({tag, "_hp"}, 32'(hp_remaining), 32'd0);
    check({tag, "_clear"}, 32'(level_clear), 32'd0);
  endtask

  initial begin
    int w0, t_ld, t_hit, t_rd, exp_hit_lat;
    int op, a;
    bit alive_obs, alive_e;
    logic [HW-1:0] rd_obs, rd_e;

    reset = 1'b1; mem_clr = 1'b1;
    ld_init = 0; ld_total = '0; ld_req = 0; ld_addr = '0; ld_health = '0;
    hit_req = 0; hit_addr = '0; rd_req = 0; rd_addr = '0;
    for (int i = 0; i < 1024; i++) ref_ram[i] = '0;
    ref_hp = 0; ref_loaded = 0;
    repeat (3) @(negedge clk);
    check_outputs_zero("por");
    mem_clr = 1'b0; reset = 1'b0;

    // Reset while the hit is in its check state: no write may follow.
    do_init(4);
    do_ld(5, 2);
    w0 = wr_cnt;
    @(negedge clk);
    hit_req = 1'b1; hit_addr = AW'(5);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    check_outputs_zero("rst_mid");
    @(negedge clk);
    hit_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    ref_hp = 0; ref_loaded = 0;
    repeat (3) @(negedge clk);
    check("rst_nowr", 32'(wr_cnt - w0), 32'd0);
    check("rst_mem5", 32'(mem[5]), 32'd2);
    check_outputs_zero("rst_after");

    // Loader fill, then collision decrements.
    do_init(3);
    do_ld(17, 1);
    do_ld(18, 2);
    do_ld(20, 0);
    check_level("fill");
    do_hit(18);
    do_hit(20);
    do_rd(18);

    // All three requesters rise together.
    exp_hit_lat = (ref_ram[17] != 0) ? 3 : 2;
    alive_e = (ref_ram[17] != 0);
    @(negedge clk);
    ld_req = 1; ld_addr = AW'(30); ld_health = 2'd3;
    hit_req = 1; hit_addr = AW'(17);
    rd_req = 1; rd_addr = AW'(18);
    t_ld = 0; t_hit = 0; t_rd = 0; alive_obs = 0; rd_obs = '0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (ld_ack)  begin t_ld = c; ld_req = 0; end
      if (hit_ack) begin t_hit = c; hit_req = 0; alive_obs = hit_alive; end
      if (rd_ack)  begin t_rd = c; rd_req = 0; rd_obs = rd_health; end
    end
    ld_req = 0; hit_req = 0; rd_req = 0;
    ref_ram[30] = 2'd3;
    if (alive_e) begin
      ref_ram[17] = ref_ram[17] - 2'd1;
      if (ref_hp != 0) ref_hp--;
    end
    rd_e = ref_ram[18];
    check("pri_ld_t", 32'(t_ld), 32'd1);
    check("pri_hit_t", 32'(t_hit), 32'(1 + 1 + exp_hit_lat));
    check("pri_rd_t", 32'(t_rd), 32'(1 + 1 + exp_hit_lat + 1 + 2));
    check("pri_alive", 32'(alive_obs), 32'(alive_e));
    check("pri_rd_data", 32'(rd_obs), 32'(rd_e));
    check("pri_mem30", 32'(mem[30]), 32'(ref_ram[30]));
    check("pri_mem17", 32'(mem[17]), 32'(ref_ram[17]));
    check_level("pri");

    // Out-of-range addresses.
    do_rd(18);
    do_rd(BNUM);
    do_rd(BNUM - 1);
    do_hit(400);
    do_hit(BNUM);

    // Level clear and reload.
    do_init(1);
    do_ld(40, 1);
    do_hit(40);
    do_hit(40);
    do_init(2);
    do_init(0);
    do_init(1);

    // Randomized mix against the reference model.
    do_init(int'($urandom_range(5, 20)));
    for (int n = 0; n < 60; n++) begin
      op = int'($urandom_range(0, 2));
      if (op == 0) do_ld(int'($urandom_range(0, BNUM - 1)), int'($urandom_range(0, 3)));
      else begin
        a = int'($urandom_range(0, 15));
        a = (a == 15) ? int'($urandom_range(BNUM, BNUM + 20)) : int'($urandom_range(0, 63));
        if (op == 1) do_hit(a);
        else         do_rd(a);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
